// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: completion status codes and initiator FSM states.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_OK              = 2'd0,
    WB_ERR             = 2'd1,
    WB_RETRY_EXHAUSTED = 2'd2,
    WB_TIMEOUT         = 2'd3
  } wb_status_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    BACKOFF = 2'd2,
    RESP    = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator with bounded retry and per-attempt timeout.
// Every output is a flop; the comb block computes next values for all of them.
module wb_initiator
  import wb_pkg::*;
#(
  parameter int MAX_RETRIES    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_adr_i,
  input  logic [3:0]  req_sel_i,
  input  logic [31:0] req_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic [1:0]  rsp_status_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);

  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  wb_state_e   state, nxt_state;
  logic [RW-1:0] retry_cnt, nxt_retry;
  logic [15:0] tmo_cnt, nxt_tmo;

  logic        nxt_req_ready, nxt_rsp_valid, nxt_cyc, nxt_stb, nxt_we;
  logic [31:0] nxt_rsp_dat, nxt_adr, nxt_dat;
  logic [1:0]  nxt_status;
  logic [3:0]  nxt_sel;

  logic        done;
  wb_status_e  done_status;
  logic [31:0] done_dat;

  always_comb begin
    nxt_state     = state;
    nxt_retry     = retry_cnt;
    nxt_tmo       = tmo_cnt;
    nxt_req_ready = req_ready_o;
    nxt_rsp_valid = rsp_valid_o;
    nxt_rsp_dat   = rsp_dat_o;
    nxt_status    = rsp_status_o;
    nxt_cyc       = cyc_o;
    nxt_stb       = stb_o;
    nxt_we        = we_o;
    nxt_adr       = adr_o;
    nxt_sel       = sel_o;
    nxt_dat       = dat_o;
    done          = 1'b0;
    done_status   = WB_OK;
    done_dat      = '0;

    case (state)
      IDLE: begin
        nxt_req_ready = 1'b1;
        if (req_valid_i && req_ready_o) begin
          nxt_we        = req_we_i;
          nxt_adr       = req_adr_i;
          nxt_sel       = req_sel_i;
          nxt_dat       = req_we_i ? req_dat_i : 32'd0;
          nxt_retry     = '0;
          nxt_tmo       = '0;
          nxt_cyc       = 1'b1;
          nxt_stb       = 1'b1;
          nxt_req_ready = 1'b0;
          nxt_state     = BUS;
        end
      end
      BUS: begin
        // err beats ack beats rty when several land in the same cycle
        if (err_i) begin
          done        = 1'b1;
          done_status = WB_ERR;
        end else if (ack_i) begin
          done        = 1'b1;
          done_status = WB_OK;
          done_dat    = we_o ? 32'd0 : dat_i;
        end else if (rty_i) begin
          if (retry_cnt < RW'(MAX_RETRIES)) begin
            nxt_retry = retry_cnt + 1'b1;
            nxt_cyc   = 1'b0;
            nxt_stb   = 1'b0;
            nxt_state = BACKOFF;
          end else begin
            done        = 1'b1;
            done_status = WB_RETRY_EXHAUSTED;
          end
        end else if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          done        = 1'b1;
          done_status = WB_TIMEOUT;
        end else begin
          nxt_tmo = tmo_cnt + 16'd1;
        end
      end
      BACKOFF: begin
        nxt_tmo   = '0;
        nxt_cyc   = 1'b1;
        nxt_stb   = 1'b1;
        nxt_state = BUS;
      end
      RESP: begin
        if (rsp_ready_i) begin
          nxt_rsp_valid = 1'b0;
          nxt_req_ready = 1'b1;
          nxt_state     = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase

    if (done) begin
      nxt_cyc       = 1'b0;
      nxt_stb       = 1'b0;
      nxt_we        = 1'b0;
      nxt_dat       = '0;
      nxt_rsp_valid = 1'b1;
      nxt_rsp_dat   = done_dat;
      nxt_status    = done_status;
      nxt_state     = RESP;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      retry_cnt    <= '0;
      tmo_cnt      <= '0;
      req_ready_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= '0;
      rsp_status_o <= '0;
      cyc_o        <= 1'b0;
      stb_o        <= 1'b0;
      we_o         <= 1'b0;
      adr_o        <= '0;
      sel_o        <= '0;
      dat_o        <= '0;
    end else begin
      state        <= nxt_state;
      retry_cnt    <= nxt_retry;
      tmo_cnt      <= nxt_tmo;
      req_ready_o  <= nxt_req_ready;
      rsp_valid_o  <= nxt_rsp_valid;
      rsp_dat_o    <= nxt_rsp_dat;
      rsp_status_o <= nxt_status;
      cyc_o        <= nxt_cyc;
      stb_o        <= nxt_stb;
      we_o         <= nxt_we;
      adr_o        <= nxt_adr;
      sel_o        <= nxt_sel;
      dat_o        <= nxt_dat;
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Randomized scoreboard bench for wb_initiator with a scripted Wishbone responder.
module tb_wb_initiator;

  localparam int MAXR = 4;
  localparam int TMO  = 8;
  localparam int K_ACK = 0, K_ERR = 1, K_ERRACK = 2, K_NONE = 3, K_RTY = 4;

  logic        clk, rst_i;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_adr_i, req_dat_i;
  logic [3:0]  req_sel_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_status_o;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o, dat_i;
  logic [3:0]  sel_o;
  logic        ack_i, err_i, rty_i;

  wb_initiator #(.MAX_RETRIES(MAXR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_sel_i(req_sel_i), .req_dat_i(req_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_status_o(rsp_status_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .sel_o(sel_o),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  st;
    logic [31:0] data;
    int          pulses, high, lat, vcyc;
    logic        we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // responder script for the current transaction
  int          r_D = 1, r_rty_n = 0, r_final = K_ACK, r_att = 0, r_rdly = 0;
  logic [31:0] r_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Outcome from the protocol rules: each attempt lasts D+1 strobe cycles
  // unless it hits the timeout; rty re-issues after a one-cycle gap.
  function automatic exp_t model(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                                 input logic [31:0] wdat, input int D, input int rty_n,
                                 input int fin, input logic [31:0] rdat, input int rdly);
    exp_t e;
    int retries = 0, attempts = 0, high = 0, kind;
    e.st = 2'd0; e.data = 32'd0;
    for (int i = 0; i < 100; i++) begin
      attempts++;
      kind = (attempts - 1 < rty_n) ? K_RTY : fin;
      if (kind == K_NONE || D >= TMO) begin
        high += TMO; e.st = 2'd3; break;
      end
      high += D + 1;
      if (kind == K_ERR || kind == K_ERRACK) begin e.st = 2'd1; break; end
      if (kind == K_ACK) begin e.st = 2'd0; e.data = we ? 32'd0 : rdat; break; end
      if (retries < MAXR) retries++;
      else begin e.st = 2'd2; break; end
    end
    e.pulses = attempts;
    e.high   = high;
    e.lat    = high + attempts;
    e.vcyc   = rdly + 1;
    e.we     = we;
    e.adr    = adr;
    e.sel    = sel;
    e.wdat   = we ? wdat : 32'd0;
    return e;
  endfunction

  // Wishbone responder: terminates on the D-th strobe cycle of each attempt,
  // and throws stray terminations while stb_o is low.
  initial begin
    int att_cyc = 0;
    int kind;
    ack_i = 0; err_i = 0; rty_i = 0; dat_i = 0;
    forever begin
      @(negedge clk);
      ack_i = 0; err_i = 0; rty_i = 0; dat_i = $urandom;
      if (stb_o) begin
        kind = (r_att < r_rty_n) ? K_RTY : r_final;
        if (att_cyc == r_D) begin
          case (kind)
            K_RTY:    begin rty_i = 1; r_att++; end
            K_ACK:    begin ack_i = 1; dat_i = r_data; end
            K_ERR:    err_i = 1;
            K_ERRACK: begin err_i = 1; ack_i = 1; dat_i = r_data; end
            default:  ;
          endcase
        end
        att_cyc++;
      end else begin
        att_cyc = 0;
        if ($urandom_range(0, 3) == 0) {ack_i, err_i, rty_i} = 3'($urandom_range(1, 7));
      end
    end
  end

  // core-side response acceptor: holds ready low for r_rdly valid cycles
  initial begin
    int hc = 0;
    rsp_ready_i = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid_o) begin
        hc++;
        rsp_ready_i = (hc > r_rdly);
      end else begin
        hc = 0;
        rsp_ready_i = 1'($urandom_range(0, 1));
      end
    end
  end

  // monitor: measures each transaction on the bus and scores it at the response handshake
  initial begin
    bit in_txn = 0, prev_stb = 0, fld_bad = 0, hold_bad = 0;
    int lat = 0, high = 0, pulses = 0, vcyc = 0, first_lat = 0;
    logic [31:0] h_dat;
    logic [1:0]  h_st;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_i) begin
        in_txn = 0; prev_stb = 0;
      end else begin
        if (in_txn) begin
          lat++;
          if (stb_o) begin
            high++;
            if (!prev_stb) pulses++;
            if (q.size() > 0 && (!cyc_o || adr_o !== q[0].adr || sel_o !== q[0].sel ||
                we_o !== q[0].we || dat_o !== q[0].wdat)) fld_bad = 1;
          end
          if (rsp_valid_o) begin
            vcyc++;
            if (vcyc == 1) begin first_lat = lat; h_dat = rsp_dat_o; h_st = rsp_status_o; end
            else if (rsp_dat_o !== h_dat || rsp_status_o !== h_st) hold_bad = 1;
            if (rsp_ready_i) begin
              if (q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
              else begin
                e = q.pop_front();
                chk("status", 32'(rsp_status_o), 32'(e.st));
                chk("rsp_dat", rsp_dat_o, e.data);
                chk("stb_pulses", 32'(pulses), 32'(e.pulses));
                chk("stb_cycles", 32'(high), 32'(e.high));
                chk("rsp_latency", 32'(first_lat), 32'(e.lat));
                chk("rsp_hold_cycles", 32'(vcyc), 32'(e.vcyc));
                chk("bus_fields_ok", 32'(fld_bad | hold_bad), 32'd0);
              end
              in_txn = 0;
            end
          end
        end else if (rsp_valid_o && rsp_ready_i) begin
          chk("rsp_outside_txn", 32'd1, 32'd0);
        end
        prev_stb = stb_o;
        if (req_valid_i && req_ready_o) begin
          in_txn = 1; lat = 0; high = 0; pulses = 0; vcyc = 0;
          first_lat = 0; fld_bad = 0; hold_bad = 0;
        end
      end
    end
  end

  task automatic wait_ready(input string nm, input int limit);
    int n = 0;
    while (!req_ready_o && n < limit) begin @(negedge clk); n++; end
    if (!req_ready_o) chk(nm, 32'd0, 32'd1);
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] wdat, input int D, input int rty_n, input int fin,
                       input logic [31:0] rdat, input int rdly, input bit score);
    if (score) q.push_back(model(we, adr, sel, wdat, D, rty_n, fin, rdat, rdly));
    @(negedge clk);
    r_D = D; r_rty_n = rty_n; r_final = fin; r_data = rdat; r_att = 0; r_rdly = rdly;
    req_we_i = we; req_adr_i = adr; req_sel_i = sel; req_dat_i = wdat;
    req_valid_i = 1;
    wait_ready("req_ready_timeout", 200);
    @(negedge clk);
    req_valid_i = 0;
    req_dat_i = $urandom; req_adr_i = $urandom;
  endtask

  task automatic run(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                     input logic [31:0] wdat, input int D, input int rty_n, input int fin,
                     input logic [31:0] rdat, input int rdly);
    issue(we, adr, sel, wdat, D, rty_n, fin, rdat, rdly, 1'b1);
    wait_ready("txn_timeout", 400);
  endtask

  initial begin
    int fin, vcount;
    rst_i = 0; req_valid_i = 0; req_we_i = 0; req_adr_i = 0; req_sel_i = 0; req_dat_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({req_ready_o, rsp_valid_o, cyc_o, stb_o, we_o, rsp_status_o}), 32'd0);
    chk("rst_data", adr_o | dat_o | rsp_dat_o | 32'(sel_o), 32'd0);
    rst_i = 1;
    wait_ready("ready_after_reset", 10);

    run(1'b0, 32'h8000_0010, 4'hF, 32'h0,         1, 0,  K_ACK,    32'hDEAD_BEEF, 0);
    run(1'b1, 32'h2000_0004, 4'h3, 32'h1234_5678, 1, 0,  K_ACK,    32'h5555_AAAA, 4);
    run(1'b0, 32'h0000_0100, 4'hF, 32'h0,         1, 2,  K_ACK,    32'hCAFE_F00D, 1);
    run(1'b0, 32'h0000_0200, 4'hF, 32'h0,         1, 99, K_ACK,    32'h1111_2222, 0);
    run(1'b0, 32'h0000_0300, 4'h1, 32'h0,         0, 0,  K_ERRACK, 32'h3333_4444, 2);
    run(1'b1, 32'h0000_0400, 4'hC, 32'hABCD_0123, 0, 0,  K_NONE,   32'h0,         0);

    // reset while strobing: bus drops, no response ever appears
    issue(1'b0, 32'h0000_0500, 4'hF, 32'h0, 0, 0, K_NONE, 32'h0, 0, 1'b0);
    repeat (2) @(negedge clk);
    rst_i = 0;
    @(negedge clk);
    rst_i = 1;
    chk("rst_mid_cyc", 32'({cyc_o, stb_o}), 32'd0);
    vcount = 0;
    repeat (20) begin @(negedge clk); if (rsp_valid_o) vcount++; end
    chk("rst_no_rsp", 32'(vcount), 32'd0);
    wait_ready("ready_after_mid_reset", 10);
    run(1'b0, 32'h8000_0020, 4'hF, 32'h0, 2, 0, K_ACK, 32'h0BAD_F00D, 1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: fin = K_ACK;
        3:       fin = K_ERR;
        4:       fin = K_ERRACK;
        default: fin = K_NONE;
      endcase
      run(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)), $urandom,
          int'($urandom_range(0, 9)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0,
          fin, $urandom, int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
